// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM state encoding and register-file sizing
package alu_seq_pkg;
    localparam int NREG = 4;
    localparam int RW = 2;
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_NOT = 3'b010,
        OP_SHL = 3'b011,
        OP_SHR = 3'b100,
        OP_ADD = 3'b101,
        OP_SUB = 3'b110,
        OP_MUL = 3'b111
    } op_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/bit8alu.sv
// bit8alu: combinational datapath producing result, product high half and raw flags
module bit8alu
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              s,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] mulh,
    output logic [7:0]       flag
);
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        dif  = {1'b0, a} - {1'b0, b};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        acc  = s == OP_AND ? a & b :
               s == OP_OR  ? a | b :
               s == OP_NOT ? ~a :
               s == OP_SHL ? a << 1 :
               s == OP_ADD ? sum[WIDTH-1:0] :
               s == OP_SUB ? dif[WIDTH-1:0] :
               s == OP_MUL ? prod[WIDTH-1:0] : '0;
        mulh = prod[2*WIDTH-1:WIDTH];
        flag = {&acc, ~|acc, dif[WIDTH], sum[WIDTH], a[0], a[WIDTH-1], &a, ~|a};
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command-sequenced register-file ALU with load/exec/response handshake
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = alu_seq_pkg::NREG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_ld,
    input  logic [2:0]       in_op,
    input  logic [RW-1:0]    in_rd,
    input  logic [RW-1:0]    in_rs1,
    input  logic [RW-1:0]    in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       out_flag,
    output logic             busy
);
    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_t              op_q;
    logic [RW-1:0]    rd_q;
    logic [RW-1:0]    rd_hi;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mulh;
    logic [WIDTH-1:0] res;
    logic [7:0]       aflag;
    logic [7:0]       new_flag;
    logic             accept;

    bit8alu #(.WIDTH(WIDTH)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .s    (op_q),
        .acc  (acc),
        .mulh (mulh),
        .flag (aflag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == RESP;
        busy      = state != IDLE;
        accept    = in_valid & in_ready;
        nxt       = state == IDLE ? (in_valid ? (in_ld ? RESP : EXEC) : IDLE) :
                    state == EXEC ? RESP :
                    out_ready     ? IDLE : RESP;
        rd_hi     = rd_q == RW'(NREG - 1) ? '0 : rd_q + RW'(1);
        // SHR is formed here rather than trusting the shared ALU output
        res       = op_q == OP_SHR ? a_q >> 1 : acc;
        new_flag  = {&res, ~|res,
                     op_q == OP_SUB ? aflag[5] : out_flag[5],
                     op_q == OP_ADD ? aflag[4] : out_flag[4],
                     aflag[3:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            rd_q     <= '0;
            out_data <= '0;
            out_flag <= '0;
        end else if (accept && in_ld) begin
            regs[in_rd] <= in_imm;
            out_data    <= in_imm;
        end else if (accept) begin
            a_q  <= regs[in_rs1];
            b_q  <= regs[in_rs2];
            op_q <= op_t'(in_op);
            rd_q <= in_rd;
        end else if (state == EXEC) begin
            regs[rd_q] <= res;
            if (op_q == OP_MUL)
                regs[rd_hi] <= mulh;
            out_data <= res;
            out_flag <= new_flag;
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench with directed cases and randomized commands against a reference model
module tb_alu_seq_ctrl;
    logic       clk = 0;
    logic       rst = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic       in_ld = 0;
    logic [2:0] in_op = 0;
    logic [1:0] in_rd = 0;
    logic [1:0] in_rs1 = 0;
    logic [1:0] in_rs2 = 0;
    logic [7:0] in_imm = 0;
    logic       out_valid;
    logic       out_ready = 1;
    logic [7:0] out_data;
    logic [7:0] out_flag;
    logic       busy;

    typedef struct {
        int   data;
        int   flag;
        time  t_acc;
        int   lat;
    } exp_t;

    exp_t       q[$];
    int         mreg[4];
    logic [7:0] mflag = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         ready_mode = 0;
    logic       pv = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(8), .NREG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ld     (in_ld),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit ld, input int op, input int rd, input int rs1, input int rs2, input int imm);
        int         w = 0;
        int         a, b, r, h;
        logic [7:0] nf;
        exp_t       e;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1;
        in_ld    = ld;
        in_op    = 3'(op);
        in_rd    = 2'(rd);
        in_rs1   = 2'(rs1);
        in_rs2   = 2'(rs2);
        in_imm   = 8'(imm);
        @(posedge clk);
        e.t_acc = $time;
        if (ld) begin
            mreg[rd] = imm;
            e.data   = imm;
            e.flag   = int'(mflag);
            e.lat    = 1;
        end else begin
            a = mreg[rs1];
            b = mreg[rs2];
            h = 0;
            case (op)
                0: r = a & b;
                1: r = a | b;
                2: r = 255 - a;
                3: r = (a * 2) % 256;
                4: r = a / 2;
                5: r = (a + b) % 256;
                6: r = (a - b + 256) % 256;
                default: begin
                    r = (a * b) % 256;
                    h = (a * b) / 256;
                end
            endcase
            nf[0] = a == 0;
            nf[1] = a == 255;
            nf[2] = a >= 128;
            nf[3] = a % 2 == 1;
            nf[4] = op == 5 ? a + b > 255 : mflag[4];
            nf[5] = op == 6 ? a < b : mflag[5];
            nf[6] = r == 0;
            nf[7] = r == 255;
            mflag    = nf;
            mreg[rd] = r;
            if (op == 7)
                mreg[(rd + 1) % 4] = h;
            e.data = r;
            e.flag = int'(nf);
            e.lat  = 2;
        end
        q.push_back(e);
        #1 in_valid = 0;
    endtask

    task automatic see(input string name, input int d, input int fm, input int fv);
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data, d);
        if (fm != 0)
            chk({name, "_flag"}, out_flag & 8'(fm), fv);
    endtask

    task automatic drain();
        int w = 0;
        while ((q.size() != 0 || !in_ready) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1)
            out_ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 0)
            out_ready = 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv = 0;
        end else begin
            chk("busy_vs_ready", busy, !in_ready);
            if (out_valid) begin
                chk("ready_low_in_resp", in_ready, 0);
                if (q.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    e = q[0];
                    chk("sb_data", out_data, e.data);
                    chk("sb_flag", out_flag, e.flag);
                    if (!pv)
                        chk("sb_latency", int'(($time - e.t_acc + 5) / 10), e.lat);
                    if (out_ready)
                        void'(q.pop_front());
                end
            end
            pv = out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #1 rst = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_flag", out_flag, 0);
        @(negedge clk);
        rst = 0;
        // basic add
        issue(1, 0, 0, 0, 0, 'h0F);
        issue(1, 0, 1, 0, 0, 'h33);
        issue(0, 5, 2, 0, 1, 0);
        see("add", 'h42, 'h10, 0);
        // carry then borrow, carry must hold across SUB
        issue(1, 0, 0, 0, 0, 'hFF);
        issue(1, 0, 1, 0, 0, 'h01);
        issue(0, 5, 2, 0, 1, 0);
        see("add_carry", 'h00, 'h50, 'h50);
        issue(0, 6, 3, 1, 0, 0);
        see("sub_borrow", 'h02, 'h30, 'h30);
        // MUL high half wraps into r0
        issue(1, 0, 3, 0, 0, 'h10);
        issue(1, 0, 0, 0, 0, 'h20);
        issue(0, 7, 3, 3, 0, 0);
        see("mul_lo", 'h00, 0, 0);
        issue(0, 1, 1, 0, 0, 0);
        see("mul_hi_wrap", 'h02, 0, 0);
        // shifts and NOT
        issue(1, 0, 0, 0, 0, 'h81);
        issue(0, 4, 1, 0, 0, 0);
        see("shr", 'h40, 0, 0);
        issue(0, 3, 1, 0, 0, 0);
        see("shl", 'h02, 0, 0);
        issue(1, 0, 2, 0, 0, 'h00);
        issue(0, 2, 3, 2, 0, 0);
        see("not", 'hFF, 'h80, 'h80);
        drain();
        // stall in RESP with a stray command presented
        ready_mode = 2;
        out_ready  = 0;
        issue(0, 5, 1, 0, 2, 0);
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("stall_valid", out_valid, 1);
        in_ld  = 1;
        in_rd  = 0;
        in_imm = 8'hAA;
        in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_data", out_data, 8'h81);
        end
        @(posedge clk);
        #1 in_valid = 0;
        out_ready  = 1;
        ready_mode = 0;
        issue(0, 1, 1, 0, 0, 0);
        see("ignored_cmd", 'h81, 0, 0);
        drain();
        // reset during EXEC aborts the write
        issue(0, 5, 2, 0, 0, 0);
        rst = 1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_data", out_data, 0);
        foreach (mreg[i]) mreg[i] = 0;
        mflag = 0;
        q.delete();
        @(negedge clk);
        rst = 0;
        issue(0, 1, 3, 2, 2, 0);
        see("abort_dest_zero", 'h00, 0, 0);
        drain();
        // randomized traffic with random backpressure
        ready_mode = 1;
        repeat (150)
            issue($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        drain();
        ready_mode = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
